systolic_ctrl: RTL and testbench

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/systolic_ctrl_if.sv | 28 ++
 rtl/systolic_ctrl.sv | 121 ++++++++++++
 tb/tb_systolic_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_ctrl_if.sv
// Control bundle between the systolic-array sequencer and its surroundings.
// The master side is the sequencer; the slave side is the host/array/consumer.
interface systolic_ctrl_if #(
   parameter int DIM = 8,
   parameter int CW  = $clog2(DIM)
);
   logic           start;
   logic           abort;
   logic           busy;
   logic           done;
   logic           mac_en;
   logic           mac_wren;
   logic [CW-1:0]  crow;
   logic [DIM-1:0] a_rd;
   logic [DIM-1:0] b_rd;
   logic           rd_valid;
   logic           rd_ready;

   modport master (
      input  start, abort, rd_ready,
      output busy, done, mac_en, mac_wren, crow, a_rd, b_rd, rd_valid
   );

   modport slave (
      output start, abort, rd_ready,
      input  busy, done, mac_en, mac_wren, crow, a_rd, b_rd, rd_valid
   );
endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for a DIM x DIM systolic MAC array: clear C, stream skewed A/B,
// then hand C out row by row under a valid/ready handshake.
module systolic_ctrl #(
   parameter int DIM = 8,
   parameter int CW  = $clog2(DIM)
) (
   input  logic               clk,
   input  logic               rst_n,
   systolic_ctrl_if.master    bus
);

   localparam int            KW     = $clog2(3*DIM-2);
   localparam logic [KW-1:0] K_LAST = KW'(3*DIM-3);
   localparam logic [CW-1:0] C_LAST = CW'(DIM-1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_COMPUTE,
      S_READ,
      S_DONE
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [KW-1:0] r_k;
   logic [KW-1:0] w_k_nxt;
   logic [CW-1:0] r_crow;
   logic [CW-1:0] w_crow_nxt;
   logic [DIM-1:0] w_skew;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_k     <= '0;
         r_crow  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_k     <= w_k_nxt;
         r_crow  <= w_crow_nxt;
      end
   end

   // Counters are cleared on every state exit so they never wrap past their last value.
   always_comb begin
      w_state_nxt = r_state;
      w_k_nxt     = r_k;
      w_crow_nxt  = r_crow;
      if (r_state != S_IDLE && bus.abort) begin
         w_state_nxt = S_IDLE;
         w_k_nxt     = '0;
         w_crow_nxt  = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_k_nxt    = '0;
               w_crow_nxt = '0;
               if (bus.start && !bus.abort) begin
                  w_state_nxt = S_CLEAR;
               end
            end
            S_CLEAR: begin
               if (r_crow == C_LAST) begin
                  w_state_nxt = S_COMPUTE;
                  w_crow_nxt  = '0;
               end else begin
                  w_crow_nxt = r_crow + CW'(1);
               end
            end
            S_COMPUTE: begin
               if (r_k == K_LAST) begin
                  w_state_nxt = S_READ;
                  w_k_nxt     = '0;
                  w_crow_nxt  = '0;
               end else begin
                  w_k_nxt = r_k + KW'(1);
               end
            end
            S_READ: begin
               if (bus.rd_ready) begin
                  if (r_crow == C_LAST) begin
                     w_state_nxt = S_DONE;
                     w_crow_nxt  = '0;
                  end else begin
                     w_crow_nxt = r_crow + CW'(1);
                  end
               end
            end
            S_DONE: begin
               w_state_nxt = S_IDLE;
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_k_nxt     = '0;
               w_crow_nxt  = '0;
            end
         endcase
      end
   end

   // Row/column i is fed during the DIM-cycle window starting at k = i.
   always_comb begin
      w_skew = '0;
      for (int i = 0; i < DIM; i++) begin
         w_skew[i] = (r_state == S_COMPUTE) &&
                     (int'(r_k) >= i) && (int'(r_k) <= i + DIM - 1);
      end
   end

   always_comb begin
      bus.busy     = (r_state != S_IDLE);
      bus.done     = (r_state == S_DONE);
      bus.mac_en   = (r_state == S_COMPUTE);
      bus.mac_wren = (r_state == S_CLEAR);
      bus.rd_valid = (r_state == S_READ);
      bus.crow     = r_crow;
      bus.a_rd     = w_skew;
      bus.b_rd     = w_skew;
   end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl at DIM=8 with a behavioural 8x8 MAC array
// fed from the controller strobes so the read rows can be compared to a golden product.
module tb_systolic_ctrl;

   localparam int DIM = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_err = 0;
   int   n_chk = 0;

   systolic_ctrl_if #(.DIM(DIM)) bus ();

   systolic_ctrl #(.DIM(DIM)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural array ----------------
   logic signed [7:0]  ma [DIM][DIM];
   logic signed [7:0]  mb [DIM][DIM];
   logic signed [15:0] mc [DIM][DIM];
   int pa [DIM];
   int pb [DIM];

   function automatic logic signed [7:0] a_val(int i, int j);
      return 8'(i*8 + j - 32);
   endfunction

   function automatic logic signed [7:0] b_val(int i, int j);
      return (i == j) ? 8'sd1 : 8'sd0;
   endfunction

   function automatic logic signed [7:0] feed_a(int i, int j);
      if (j == 0) return bus.a_rd[i] ? a_val(i, pa[i]) : 8'sd0;
      return ma[i][j-1];
   endfunction

   function automatic logic signed [7:0] feed_b(int i, int j);
      if (i == 0) return bus.b_rd[j] ? b_val(pb[j], j) : 8'sd0;
      return mb[i-1][j];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DIM; i++) begin
            pa[i] <= 0;
            pb[i] <= 0;
            for (int j = 0; j < DIM; j++) begin
               ma[i][j] <= '0;
               mb[i][j] <= '0;
               mc[i][j] <= 16'sh5A5A;
            end
         end
      end else begin
         if (bus.mac_wren) begin
            for (int j = 0; j < DIM; j++) mc[bus.crow][j] <= '0;
            for (int i = 0; i < DIM; i++) begin
               pa[i] <= 0;
               pb[i] <= 0;
            end
         end
         if (bus.mac_en) begin
            for (int i = 0; i < DIM; i++) begin
               if (bus.a_rd[i]) pa[i] <= pa[i] + 1;
               if (bus.b_rd[i]) pb[i] <= pb[i] + 1;
               for (int j = 0; j < DIM; j++) begin
                  ma[i][j] <= feed_a(i, j);
                  mb[i][j] <= feed_b(i, j);
                  mc[i][j] <= mc[i][j] + 16'(feed_a(i, j)) * 16'(feed_b(i, j));
               end
            end
         end
      end
   end

   function automatic logic [127:0] model_row(int r);
      logic [127:0] v;
      v = '0;
      for (int j = 0; j < DIM; j++) v[j*16 +: 16] = mc[r][j];
      return v;
   endfunction

   function automatic logic [127:0] gold_row(int r);
      logic [127:0] v;
      int s;
      v = '0;
      for (int j = 0; j < DIM; j++) begin
         s = 0;
         for (int m = 0; m < DIM; m++) s += int'(a_val(r, m)) * int'(b_val(m, j));
         v[j*16 +: 16] = 16'(s);
      end
      return v;
   endfunction

   // ---------------- expected control outputs ----------------
   function automatic logic [23:0] obs_vec();
      return {bus.busy, bus.done, bus.mac_en, bus.mac_wren, bus.rd_valid,
              bus.crow, bus.a_rd, bus.b_rd};
   endfunction

   // Cycle c counts negedges after the start pulse was sampled (first busy cycle = 1).
   function automatic logic [23:0] exp_nom(int c);
      logic       busy, done, en, wr, rv;
      logic [2:0] cr;
      logic [7:0] sk;
      int         k;
      busy = (c >= 1 && c <= 39);
      done = (c == 39);
      wr   = (c >= 1 && c <= 8);
      en   = (c >= 9 && c <= 30);
      rv   = (c >= 31 && c <= 38);
      cr   = wr ? 3'(c - 1) : (rv ? 3'(c - 31) : 3'd0);
      k    = c - 9;
      sk   = '0;
      if (en) for (int i = 0; i < DIM; i++) sk[i] = (k >= i) && (k <= i + 7);
      return {busy, done, en, wr, rv, cr, sk, sk};
   endfunction

   function automatic logic [23:0] nom_mask(int c);
      return ((c >= 1 && c <= 8) || (c >= 31 && c <= 38)) ? 24'hFFFFFF : 24'hF8FFFF;
   endfunction

   // ---------------- scenarios ----------------
   task automatic run_nominal(input int extra_start, input string tag);
      logic [23:0] got, want, m;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.rd_ready = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         bus.start = (c == extra_start);
         m    = nom_mask(c);
         got  = obs_vec() & m;
         want = exp_nom(c) & m;
         n_chk++;
         if (got !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, c, got, want);
         end
      end
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      n_chk++;
      if (obs_vec() !== 24'h0) begin
         n_err++;
         $display("FAIL reset_async got=%h want=%h", obs_vec(), 24'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_chk++;
      if (obs_vec() !== 24'h0) begin
         n_err++;
         $display("FAIL reset_idle got=%h want=%h", obs_vec(), 24'h0);
      end
   endtask

   task automatic test_nominal();
      run_nominal(-1, "nominal");
   endtask

   task automatic test_skew();
      int         ks [5] = '{0, 7, 14, 15, 21};
      logic [7:0] ev [5] = '{8'h01, 8'hFF, 8'h80, 8'h00, 8'h00};
      int         k;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.rd_ready = 1'b1;
      for (int c = 1; c <= 39; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
         k = c - 9;
         for (int x = 0; x < 5; x++) begin
            if (c >= 9 && c <= 30 && k == ks[x]) begin
               n_chk++;
               if ({bus.a_rd, bus.b_rd} !== {ev[x], ev[x]}) begin
                  n_err++;
                  $display("FAIL skew k=%0d got a=%h b=%h want=%h", k, bus.a_rd, bus.b_rd, ev[x]);
               end
            end
         end
         if (c >= 31 && c <= 38) begin
            n_chk++;
            if (bus.crow !== 3'(c - 31) || model_row(c - 31) !== gold_row(c - 31)) begin
               n_err++;
               $display("FAIL product row=%0d crow=%0d got=%h want=%h",
                        c - 31, bus.crow, model_row(c - 31), gold_row(c - 31));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int cnt;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.rd_ready = 1'b1;
      for (int c = 1; c <= 34; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      n_chk++;
      if ({bus.rd_valid, bus.crow} !== {1'b1, 3'd3}) begin
         n_err++;
         $display("FAIL bp_reach got vld=%b crow=%0d want vld=1 crow=3", bus.rd_valid, bus.crow);
      end
      bus.rd_ready = 1'b0;
      for (int h = 0; h < 5; h++) begin
         @(negedge clk);
         n_chk++;
         if ({bus.rd_valid, bus.crow} !== {1'b1, 3'd3}) begin
            n_err++;
            $display("FAIL bp_hold h=%0d got vld=%b crow=%0d want vld=1 crow=3", h, bus.rd_valid, bus.crow);
         end
      end
      bus.rd_ready = 1'b1;
      @(negedge clk);
      n_chk++;
      if ({bus.rd_valid, bus.crow} !== {1'b1, 3'd4}) begin
         n_err++;
         $display("FAIL bp_resume got vld=%b crow=%0d want vld=1 crow=4", bus.rd_valid, bus.crow);
      end
      cnt = 0;
      while (!bus.done && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      n_chk++;
      if (cnt !== 4) begin
         n_err++;
         $display("FAIL bp_done cycles got=%0d want=4", cnt);
      end
      @(negedge clk);
      n_chk++;
      if (bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL bp_idle busy got=%b want=0", bus.busy);
      end
   endtask

   task automatic test_abort();
      logic seen;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.rd_ready = 1'b1;
      for (int c = 1; c <= 19; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      n_chk++;
      if (obs_vec() !== 24'h0) begin
         n_err++;
         $display("FAIL abort_idle got=%h want=%h", obs_vec(), 24'h0);
      end
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.done || bus.busy) seen = 1'b1;
      end
      n_chk++;
      if (seen !== 1'b0) begin
         n_err++;
         $display("FAIL abort_quiet done/busy seen=%b want=0", seen);
      end
      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      n_chk++;
      if (bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL abort_with_start busy got=%b want=0", bus.busy);
      end
      run_nominal(-1, "post_abort");
   endtask

   task automatic test_async_reset();
      logic seen;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.rd_ready = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (obs_vec() !== 24'h0) begin
         n_err++;
         $display("FAIL async_rst got=%h want=%h", obs_vec(), 24'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (bus.busy) seen = 1'b1;
      end
      n_chk++;
      if (seen !== 1'b0) begin
         n_err++;
         $display("FAIL rst_release busy seen=%b want=0", seen);
      end
      run_nominal(-1, "post_reset");
   endtask

   task automatic test_start_while_busy();
      run_nominal(11, "start_busy");
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.abort    = 1'b0;
      bus.rd_ready = 1'b0;
      test_reset();
      test_nominal();
      test_skew();
      test_backpressure();
      test_abort();
      test_async_reset();
      test_start_while_busy();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
